imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Streams a program image into the DSP instruction memory over a byte-wide valid/ready interface.
- It is the writer side of the instruction memory that the core fetches from. It replaces file preloading on hardware and in system-level benches.
- The core is held stalled while a load is in progress. The image is protected by an XOR checksum.

Parameters:
ADDR_WIDTH, 10, instruction memory address width in words (capacity 2^ADDR_WIDTH)
DATA_WIDTH, 16, instruction word width; fixed at 16 (two bytes per word)
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT_CYCLES, 1000, inter-byte timeout; used only with LOADER_TIMEOUT_EN

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
in_data  input  8  stream byte
in_valid  input  1  in_data valid
in_ready  output  1  loader can accept a byte
imem_we  output  1  instruction memory write strobe, one cycle per word
imem_addr  output  ADDR_WIDTH  word write address
imem_wdata  output  DATA_WIDTH  word write data
cpu_hold  output  1  stalls or holds the core in reset while high
done  output  1  last frame loaded and checksum matched
error  output  1  last frame failed (checksum, length or timeout)

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - in_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=0, done=0, error=0.
  - Counters and checksum are cleared.
  - A reset asserted mid-frame aborts the frame. Words already written stay in memory.
- Handshake: a byte transfers on a rising clk edge when in_valid && in_ready. in_ready is 1 in every state.
- Frame format, in order:
  - SYNC_BYTE
  - LEN_HI, LEN_LO: word count N, big-endian
  - 2N data bytes, high byte first for each word
  - CHK: XOR of all 2N data bytes
- States:
  - IDLE / DONE / ERR:
    - A byte equal to SYNC_BYTE goes to LEN_HI. It sets cpu_hold=1, clears done, error, the checksum and the address counter.
    - Any other byte is accepted and discarded.
  - LEN_HI: latch the byte as N[15:8], then go to LEN_LO.
  - LEN_LO: latch N[7:0].
    - If N > 2^ADDR_WIDTH, go to ERR.
    - Else if N == 0, go to CHK.
    - Otherwise go to DATA_HI.
  - DATA_HI: latch the high byte, XOR it into the checksum, go to DATA_LO.
  - DATA_LO: XOR the byte into the checksum.
    - On the next cycle: imem_we=1 for exactly one cycle, imem_wdata={hi,lo}, imem_addr=current word index.
    - The word index then increments.
    - If the word index reaches N, go to CHK; otherwise go to DATA_HI.
  - CHK: compare the received byte with the running checksum.
    - Equal: go to DONE with done=1 and cpu_hold=0. cpu_hold falls in the same cycle done rises.
    - Not equal: go to ERR with error=1 and cpu_hold held at 1.
- Write timing: imem_we is registered with latency 1 after the DATA_LO handshake. Back-to-back bytes give one write every two cycles.
- Address wrap: with N == 2^ADDR_WIDTH, the final write uses address 2^ADDR_WIDTH-1. The word index is ADDR_WIDTH+1 bits wide, so it never wraps before reaching N.
- Sync bytes inside the length, data or CHK fields are treated as data, not as a resync.
- done and error are mutually exclusive. They hold until the next SYNC_BYTE or reset.
- cpu_hold stays 1 in ERR, so a corrupted image never runs. It is released only by a successful frame or by reset.

Optional Feature:
LOADER_TIMEOUT_EN
- Defined:
  - A counter runs while the state is LEN_HI..CHK and no byte is being accepted. It reloads on every accepted byte.
  - When it reaches TIMEOUT_CYCLES, the state goes to ERR with error=1 and cpu_hold=1.
- Undefined: no counter. The loader waits indefinitely mid-frame. TIMEOUT_CYCLES is ignored.

Test Plan:
1. Nominal load:
   - Stimulus: A5 00 02 12 34 AB CD, then CHK = 12^34^AB^CD = 0x40.
   - Response: writes (0,0x1234) and (1,0xABCD); done=1, error=0, cpu_hold falls with done.
2. Checksum failure:
   - Stimulus: the same frame with CHK=0x41.
   - Response: both words still written; error=1, done=0, cpu_hold=1.
3. Zero length and resync:
   - Stimulus: garbage bytes 00 FF, then A5 00 00 00.
   - Response: garbage dropped, no writes, done=1.
   - Follow-up: a second valid frame restarts at address 0 and clears done during the load.
4. Oversize and boundary, with ADDR_WIDTH=4:
   - Stimulus: N=17.
   - Response: ERR right after LEN_LO, no writes.
   - Stimulus: N=16.
   - Response: last write at address 15, done=1.
5. Reset mid-frame:
   - Stimulus: drop reset low after the 3rd data byte.
   - Response: immediate return to IDLE; all outputs 0; a later full frame loads correctly.
6. Timeout (LOADER_TIMEOUT_EN, TIMEOUT_CYCLES=20):
   - Stimulus: stall 20 cycles after LEN_LO.
   - Response: error=1, cpu_hold=1.
   - Stimulus: the same stall without the macro.
   - Response: still waiting; completing the frame gives done=1.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream loader that writes a checksummed program image into instruction memory.
// Optional inter-byte timeout is enabled by defining LOADER_TIMEOUT_EN.
module imem_loader #(
    parameter int          ADDR_WIDTH     = 10,
    parameter int          DATA_WIDTH     = 16,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0] imem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA_HI,
        DATA_LO,
        CHK,
        DONE,
        ERR
    } state_t;

    localparam logic [31:0] CAPACITY = 32'd1 << ADDR_WIDTH;

    state_t                  state_q, state_nxt;
    logic [15:0]             len_q, len_nxt;
    logic [7:0]              hi_q, hi_nxt;
    logic [7:0]              chk_q, chk_nxt;
    logic [ADDR_WIDTH:0]     idx_q, idx_nxt;
    logic [ADDR_WIDTH:0]     idx_inc;
    logic [ADDR_WIDTH-1:0]   addr_nxt;
    logic [DATA_WIDTH-1:0]   wdata_nxt;
    logic                    we_nxt;
    logic                    hold_nxt;
    logic                    done_nxt;
    logic                    error_nxt;
    logic                    accept;
    logic [15:0]             len_rx;

    assign in_ready = 1'b1;
    assign accept   = in_valid && in_ready;
    assign idx_inc  = idx_q + (ADDR_WIDTH+1)'(1);
    assign len_rx   = {len_q[15:8], in_data};

`ifdef LOADER_TIMEOUT_EN
    logic [31:0] tmo_q, tmo_nxt;
`endif

    // Next-state and next-output logic; every register has a hold default.
    always_comb begin
        state_nxt = state_q;
        len_nxt   = len_q;
        hi_nxt    = hi_q;
        chk_nxt   = chk_q;
        idx_nxt   = idx_q;
        addr_nxt  = imem_addr;
        wdata_nxt = imem_wdata;
        we_nxt    = 1'b0;
        hold_nxt  = cpu_hold;
        done_nxt  = done;
        error_nxt = error;
`ifdef LOADER_TIMEOUT_EN
        tmo_nxt   = 32'd0;
`endif

        case (state_q)
            IDLE, DONE, ERR: begin
                if (accept && in_data == SYNC_BYTE) begin
                    state_nxt = LEN_HI;
                    hold_nxt  = 1'b1;
                    done_nxt  = 1'b0;
                    error_nxt = 1'b0;
                    chk_nxt   = 8'd0;
                    idx_nxt   = '0;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    len_nxt[15:8] = in_data;
                    state_nxt     = LEN_LO;
                end
            end
            LEN_LO: begin
                if (accept) begin
                    len_nxt[7:0] = in_data;
                    if ({16'd0, len_rx} > CAPACITY) begin
                        state_nxt = ERR;
                        error_nxt = 1'b1;
                    end else if (len_rx == 16'd0) begin
                        state_nxt = CHK;
                    end else begin
                        state_nxt = DATA_HI;
                    end
                end
            end
            DATA_HI: begin
                if (accept) begin
                    hi_nxt    = in_data;
                    chk_nxt   = chk_q ^ in_data;
                    state_nxt = DATA_LO;
                end
            end
            DATA_LO: begin
                if (accept) begin
                    chk_nxt   = chk_q ^ in_data;
                    we_nxt    = 1'b1;
                    wdata_nxt = {hi_q, in_data};
                    addr_nxt  = idx_q[ADDR_WIDTH-1:0];
                    idx_nxt   = idx_inc;
                    // The index is one bit wider than the address so a full image still compares equal to N.
                    if (32'(idx_inc) == 32'(len_q))
                        state_nxt = CHK;
                    else
                        state_nxt = DATA_HI;
                end
            end
            CHK: begin
                if (accept) begin
                    if (in_data == chk_q) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                        hold_nxt  = 1'b0;
                    end else begin
                        state_nxt = ERR;
                        error_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

`ifdef LOADER_TIMEOUT_EN
        if (state_q inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK} && !accept) begin
            tmo_nxt = tmo_q + 32'd1;
            if (tmo_nxt == 32'(TIMEOUT_CYCLES)) begin
                state_nxt = ERR;
                error_nxt = 1'b1;
                done_nxt  = 1'b0;
                hold_nxt  = 1'b1;
                tmo_nxt   = 32'd0;
            end
        end
`endif
    end

    // All state and outputs are registered; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            len_q      <= 16'd0;
            hi_q       <= 8'd0;
            chk_q      <= 8'd0;
            idx_q      <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
            tmo_q      <= 32'd0;
`endif
        end else begin
            state_q    <= state_nxt;
            len_q      <= len_nxt;
            hi_q       <= hi_nxt;
            chk_q      <= chk_nxt;
            idx_q      <= idx_nxt;
            imem_we    <= we_nxt;
            imem_addr  <= addr_nxt;
            imem_wdata <= wdata_nxt;
            cpu_hold   <= hold_nxt;
            done       <= done_nxt;
            error      <= error_nxt;
`ifdef LOADER_TIMEOUT_EN
            tmo_q      <= tmo_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (ADDR_WIDTH=4, TIMEOUT_CYCLES=20).
module tb_imem_loader;

    localparam int AW = 4;

    logic          clk;
    logic          reset;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [15:0]   imem_wdata;
    logic          cpu_hold;
    logic          done;
    logic          error;

    int checks   = 0;
    int failures = 0;

    logic [31:0] wr_addr [0:63];
    logic [31:0] wr_data [0:63];
    int          wr_total = 0;
    int          base;

    imem_loader #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (16),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log every write strobe mid-cycle; a strobe longer than one cycle shows up as extra entries.
    always @(negedge clk) begin
        if (imem_we === 1'b1 && wr_total < 64) begin
            wr_addr[wr_total] = 32'(imem_addr);
            wr_data[wr_total] = 32'(imem_wdata);
            wr_total = wr_total + 1;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        failures = failures + 1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks = checks + 1;
        if (observed !== expected) begin
            failures = failures + 1;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;

        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_we", 32'(imem_we), 32'd0);
        checkOutput("rst_addr", 32'(imem_addr), 32'd0);
        checkOutput("rst_wdata", 32'(imem_wdata), 32'd0);
        checkOutput("rst_hold", 32'(cpu_hold), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_error", 32'(error), 32'd0);
        reset = 1'b1;
        idleCycles(2);

        // Nominal load
        base = wr_total;
        applyStimulus(8'hA5);
        checkOutput("t1_hold_after_sync", 32'(cpu_hold), 32'd1);
        applyStimulus(8'h00); applyStimulus(8'h02);
        applyStimulus(8'h12); applyStimulus(8'h34);
        applyStimulus(8'hAB); applyStimulus(8'hCD);
        checkOutput("t1_hold_before_chk", 32'(cpu_hold), 32'd1);
        checkOutput("t1_done_before_chk", 32'(done), 32'd0);
        applyStimulus(8'h40);
        checkOutput("t1_writes", 32'(wr_total - base), 32'd2);
        checkOutput("t1_addr0", wr_addr[base], 32'd0);
        checkOutput("t1_data0", wr_data[base], 32'h1234);
        checkOutput("t1_addr1", wr_addr[base+1], 32'd1);
        checkOutput("t1_data1", wr_data[base+1], 32'hABCD);
        checkOutput("t1_done", 32'(done), 32'd1);
        checkOutput("t1_error", 32'(error), 32'd0);
        checkOutput("t1_hold", 32'(cpu_hold), 32'd0);
        idleCycles(2);

        // Checksum failure
        base = wr_total;
        applyStimulus(8'hA5);
        checkOutput("t2_done_cleared", 32'(done), 32'd0);
        applyStimulus(8'h00); applyStimulus(8'h02);
        applyStimulus(8'h12); applyStimulus(8'h34);
        applyStimulus(8'hAB); applyStimulus(8'hCD);
        applyStimulus(8'h41);
        checkOutput("t2_writes", 32'(wr_total - base), 32'd2);
        checkOutput("t2_data1", wr_data[base+1], 32'hABCD);
        checkOutput("t2_error", 32'(error), 32'd1);
        checkOutput("t2_done", 32'(done), 32'd0);
        checkOutput("t2_hold", 32'(cpu_hold), 32'd1);
        idleCycles(3);
        checkOutput("t2_hold_persists", 32'(cpu_hold), 32'd1);

        // Garbage, zero-length frame, then a restart at address 0
        base = wr_total;
        applyStimulus(8'h00); applyStimulus(8'hFF);
        checkOutput("t3_garbage_error", 32'(error), 32'd1);
        checkOutput("t3_garbage_hold", 32'(cpu_hold), 32'd1);
        applyStimulus(8'hA5); applyStimulus(8'h00); applyStimulus(8'h00);
        checkOutput("t3_zero_hold", 32'(cpu_hold), 32'd1);
        applyStimulus(8'h00);
        idleCycles(1);
        checkOutput("t3_zero_writes", 32'(wr_total - base), 32'd0);
        checkOutput("t3_zero_done", 32'(done), 32'd1);
        checkOutput("t3_zero_error", 32'(error), 32'd0);
        checkOutput("t3_zero_hold_rel", 32'(cpu_hold), 32'd0);
        base = wr_total;
        applyStimulus(8'hA5);
        checkOutput("t3_done_cleared", 32'(done), 32'd0);
        applyStimulus(8'h00); applyStimulus(8'h01);
        applyStimulus(8'hBE); applyStimulus(8'hEF);
        applyStimulus(8'h51);
        checkOutput("t3_writes", 32'(wr_total - base), 32'd1);
        checkOutput("t3_addr0", wr_addr[base], 32'd0);
        checkOutput("t3_data0", wr_data[base], 32'hBEEF);
        checkOutput("t3_done", 32'(done), 32'd1);

        // Sync byte inside the data field is plain data
        base = wr_total;
        applyStimulus(8'hA5); applyStimulus(8'h00); applyStimulus(8'h01);
        applyStimulus(8'hA5); applyStimulus(8'hA5); applyStimulus(8'h00);
        checkOutput("t3b_data", wr_data[base], 32'hA5A5);
        checkOutput("t3b_done", 32'(done), 32'd1);

        // Oversize length
        base = wr_total;
        applyStimulus(8'hA5); applyStimulus(8'h00); applyStimulus(8'h11);
        checkOutput("t4_over_error", 32'(error), 32'd1);
        checkOutput("t4_over_hold", 32'(cpu_hold), 32'd1);
        applyStimulus(8'h12); applyStimulus(8'h34);
        idleCycles(1);
        checkOutput("t4_over_writes", 32'(wr_total - base), 32'd0);

        // Full-capacity image: word i = {i, 0x80+i}; all bytes XOR to 0x00
        base = wr_total;
        applyStimulus(8'hA5); applyStimulus(8'h00); applyStimulus(8'h10);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(8'(i));
            applyStimulus(8'(8'h80 + i));
        end
        applyStimulus(8'h00);
        checkOutput("t4_full_writes", 32'(wr_total - base), 32'd16);
        for (int i = 0; i < 16; i++)
            checkOutput($sformatf("t4_full_addr%0d", i), wr_addr[base+i], 32'(i));
        checkOutput("t4_full_last_data", wr_data[base+15], 32'h0F8F);
        checkOutput("t4_full_done", 32'(done), 32'd1);
        checkOutput("t4_full_error", 32'(error), 32'd0);

        // Reset mid-frame after the 3rd data byte
        applyStimulus(8'hA5); applyStimulus(8'h00); applyStimulus(8'h02);
        applyStimulus(8'h11); applyStimulus(8'h22); applyStimulus(8'h33);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("t5_in_ready", 32'(in_ready), 32'd1);
        checkOutput("t5_we", 32'(imem_we), 32'd0);
        checkOutput("t5_addr", 32'(imem_addr), 32'd0);
        checkOutput("t5_wdata", 32'(imem_wdata), 32'd0);
        checkOutput("t5_hold", 32'(cpu_hold), 32'd0);
        checkOutput("t5_done", 32'(done), 32'd0);
        checkOutput("t5_error", 32'(error), 32'd0);
        idleCycles(2);
        reset = 1'b1;
        idleCycles(1);
        base = wr_total;
        applyStimulus(8'hA5); applyStimulus(8'h00); applyStimulus(8'h01);
        applyStimulus(8'hCA); applyStimulus(8'hFE); applyStimulus(8'h34);
        checkOutput("t5_writes", 32'(wr_total - base), 32'd1);
        checkOutput("t5_addr0", wr_addr[base], 32'd0);
        checkOutput("t5_data0", wr_data[base], 32'hCAFE);
        checkOutput("t5_done", 32'(done), 32'd1);

        // Stall 20 cycles after the length field
        base = wr_total;
        applyStimulus(8'hA5); applyStimulus(8'h00); applyStimulus(8'h01);
        idleCycles(20);
`ifdef LOADER_TIMEOUT_EN
        checkOutput("t6_tmo_error", 32'(error), 32'd1);
        checkOutput("t6_tmo_hold", 32'(cpu_hold), 32'd1);
        checkOutput("t6_tmo_done", 32'(done), 32'd0);
`else
        checkOutput("t6_wait_error", 32'(error), 32'd0);
        checkOutput("t6_wait_hold", 32'(cpu_hold), 32'd1);
        applyStimulus(8'h12); applyStimulus(8'h34); applyStimulus(8'h26);
        checkOutput("t6_writes", 32'(wr_total - base), 32'd1);
        checkOutput("t6_data0", wr_data[base], 32'h1234);
        checkOutput("t6_done", 32'(done), 32'd1);
        checkOutput("t6_hold", 32'(cpu_hold), 32'd0);
`endif

        idleCycles(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
